slow_cdc_tx: RTL and testbench



---
 rtl/slow_cdc_tx.sv | 147 ++++++++++++++
 tb/tb_slow_cdc_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_cdc_tx.sv
// rtl/slow_cdc_tx.sv - slow-domain source stage of the slow-to-fast toggle synchronizer
// Optional feature macro: CDC_TX_COUNT_EN (builds the 8-bit wrap-around launch counter on tx_count)
module slow_cdc_tx #(
  parameter int DW          = 4,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                     slow_clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  output logic                     out,
  output logic [DW-1:0]            data_out,
  input  logic                     ack_tgl,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     timeout_err,
  output logic [7:0]               tx_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] wait_cnt;
  logic          ack_s1;
  logic          ack_s2;
  logic          ack_s3;
  logic          ack_edge;
  logic          push;
  logic          pop;

  // Ready looks only at the registered level, so a same-cycle pop never frees a slot at full.
  assign in_ready = !rst && (level != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  // The only consumer of the FIFO is the launch out of IDLE.
  assign pop      = (state == IDLE) && (level != '0);
  assign ack_edge = ack_s2 ^ ack_s3;
  assign busy     = (state != IDLE) || (level != '0);

  // Three-flop synchronizer for the fast-domain toggle; the last two flops form the edge detector.
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
      ack_s3 <= 1'b0;
    end else begin
      ack_s1 <= ack_tgl;
      ack_s2 <= ack_s1;
      ack_s3 <= ack_s2;
    end
  end

  // FIFO storage; contents need no reset because level and pointers define validity.
  always_ff @(posedge slow_clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Handshake FSM: launch a word, hold it stable, then wait for the echoed toggle or give up.
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      out         <= 1'b0;
      data_out    <= '0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (level != '0) begin
            state    <= SEND;
            data_out <= mem[rd_ptr];
            out      <= 1'b1;
          end
        end
        SEND: begin
          state    <= WAIT_ACK;
          out      <= 1'b0;
          wait_cnt <= '0;
        end
        WAIT_ACK: begin
          // An ack arriving on the last allowed cycle still counts as a clean completion.
          if (ack_edge) begin
            state <= IDLE;
          end else if (wait_cnt == CW'(ACK_TIMEOUT - 1)) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          out   <= 1'b0;
        end
      endcase
    end
  end

`ifdef CDC_TX_COUNT_EN
  logic [7:0] tx_count_q;

  // Launch counter, wraps 255 -> 0.
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      tx_count_q <= 8'd0;
    end else if (pop) begin
      tx_count_q <= tx_count_q + 8'd1;
    end
  end

  assign tx_count = tx_count_q;
`else
  assign tx_count = 8'd0;
`endif

endmodule

// File: tb/tb_slow_cdc_tx.sv
// tb/tb_slow_cdc_tx.sv - directed self-checking bench for slow_cdc_tx
module tb_slow_cdc_tx;

  logic       slow_clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out;
  logic [3:0] data_out;
  logic       busy;
  logic [2:0] level;
  logic       timeout_err;
  logic [7:0] tx_count;
  logic       ack_echo;
  logic       ack_stray;
  logic       ack_tgl;

  int checks;
  int failures;
  int exp_tx;
  int ack_delay;
  bit ack_en;

  logic [3:0] launch_log [64];
  int         launch_n;
  int         wide_cnt;
  int         glitch_cnt;
  logic       mon_prev_out;
  logic [3:0] mon_prev_data;

  assign ack_tgl = ack_echo ^ ack_stray;

  slow_cdc_tx #(.DW(4), .DEPTH(4), .ACK_TIMEOUT(15)) dut (
    .slow_clk    (slow_clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out         (out),
    .data_out    (data_out),
    .ack_tgl     (ack_tgl),
    .busy        (busy),
    .level       (level),
    .timeout_err (timeout_err),
    .tx_count    (tx_count)
  );

  initial slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  function automatic logic [7:0] exp_txc();
`ifdef CDC_TX_COUNT_EN
    return exp_tx[7:0];
`else
    return 8'd0;
`endif
  endfunction

  // fast-side model: echo a toggle ack_delay cycles after each observed launch
  initial begin
    ack_echo = 1'b0;
    forever begin
      @(posedge slow_clk);
      #1;
      if (out === 1'b1 && ack_en) begin
        repeat (ack_delay) @(posedge slow_clk);
        #1 ack_echo = ~ack_echo;
      end
    end
  end

  // launch monitor: logs launched words, flags wide pulses and data_out changes outside a launch
  initial begin
    launch_n = 0; wide_cnt = 0; glitch_cnt = 0;
    mon_prev_out = 1'b0; mon_prev_data = 4'h0;
    forever begin
      @(posedge slow_clk);
      #1;
      if (rst !== 1'b0) begin
        mon_prev_out = 1'b0;
        mon_prev_data = 4'h0;
      end else begin
        if (out === 1'b1) begin
          if (mon_prev_out) wide_cnt++;
          if (launch_n < 64) launch_log[launch_n] = data_out;
          launch_n++;
        end else if (data_out !== mon_prev_data) begin
          glitch_cnt++;
        end
        mon_prev_out = out;
        mon_prev_data = data_out;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0;
    repeat (3) @(posedge slow_clk);
    #1;
    exp_tx = 0;
    checks++; if (out !== 1'b0) begin failures++; $display("FAIL reset_out: got %0b exp 0", out); end
    checks++; if (data_out !== 4'h0) begin failures++; $display("FAIL reset_data_out: got %0h exp 0", data_out); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %0b exp 0", in_ready); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d exp 0", level); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err: got %0b exp 0", timeout_err); end
    checks++; if (tx_count !== 8'd0) begin failures++; $display("FAIL reset_tx_count: got %0d exp 0", tx_count); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %0b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL release_busy: got %0b exp 0", busy); end
  endtask

  task automatic test_single();
    int base, n, w0;
    base = launch_n; w0 = wide_cnt + glitch_cnt;
    ack_en = 1'b1; ack_delay = 3;
    @(posedge slow_clk); #1;
    in_valid = 1'b1; in_data = 4'hA;
    @(posedge slow_clk); #1;
    in_valid = 1'b0;
    checks++; if (level !== 3'd1 || out !== 1'b0) begin failures++; $display("FAIL single_after_push: got level=%0d out=%0b exp level=1 out=0", level, out); end
    @(posedge slow_clk); #1;
    exp_tx++;
    checks++; if (out !== 1'b1 || data_out !== 4'hA) begin failures++; $display("FAIL single_launch: got out=%0b data=%0h exp out=1 data=a", out, data_out); end
    checks++; if (tx_count !== exp_txc()) begin failures++; $display("FAIL single_tx_count: got %0d exp %0d", tx_count, exp_txc()); end
    @(posedge slow_clk); #1;
    checks++; if (out !== 1'b0 || data_out !== 4'hA) begin failures++; $display("FAIL single_pulse_width: got out=%0b data=%0h exp out=0 data=a", out, data_out); end
    n = 0;
    while (busy !== 1'b0 && n < 30) begin @(posedge slow_clk); #1; n++; end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle: got busy=%0b exp 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL single_timeout_err: got %0b exp 0", timeout_err); end
    checks++; if (launch_n - base !== 1 || launch_log[base] !== 4'hA) begin failures++; $display("FAIL single_log: got n=%0d w=%0h exp n=1 w=a", launch_n - base, launch_log[base]); end
    checks++; if (wide_cnt + glitch_cnt !== w0) begin failures++; $display("FAIL single_stability: got %0d exp %0d", wide_cnt + glitch_cnt, w0); end
  endtask

  task automatic test_burst();
    int base, n, w0;
    bit acc, saw_full, full_bad;
    base = launch_n; w0 = wide_cnt + glitch_cnt;
    ack_en = 1'b1; ack_delay = 6;
    saw_full = 1'b0; full_bad = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      acc = 1'b0; n = 0;
      while (!acc && n < 100) begin
        if (level == 3'd4) begin
          saw_full = 1'b1;
          if (in_ready !== 1'b0) full_bad = 1'b1;
        end
        acc = in_ready;
        @(posedge slow_clk); #1;
        n++;
      end
    end
    in_valid = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin @(posedge slow_clk); #1; n++; end
    exp_tx += 6;
    checks++; if (saw_full !== 1'b1) begin failures++; $display("FAIL burst_reached_full: got %0b exp 1", saw_full); end
    checks++; if (full_bad !== 1'b0) begin failures++; $display("FAIL burst_ready_at_full: got %0b exp 0", full_bad); end
    checks++; if (launch_n - base !== 6) begin failures++; $display("FAIL burst_count: got %0d exp 6", launch_n - base); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (launch_log[base + i] !== 4'(i + 1)) begin failures++; $display("FAIL burst_order[%0d]: got %0h exp %0h", i, launch_log[base + i], i + 1); end
    end
    checks++; if (wide_cnt + glitch_cnt !== w0) begin failures++; $display("FAIL burst_stability: got %0d exp %0d", wide_cnt + glitch_cnt, w0); end
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL burst_end: got err=%0b busy=%0b exp 0 0", timeout_err, busy); end
    checks++; if (tx_count !== exp_txc()) begin failures++; $display("FAIL burst_tx_count: got %0d exp %0d", tx_count, exp_txc()); end
  endtask

  task automatic test_stray_ack();
    int base, n;
    base = launch_n;
    ack_en = 1'b1; ack_delay = 3;
    @(posedge slow_clk); #1;
    ack_stray = ~ack_stray;
    repeat (6) @(posedge slow_clk);
    #1;
    checks++; if (busy !== 1'b0 || launch_n !== base) begin failures++; $display("FAIL stray_ignored: got busy=%0b launches=%0d exp 0 0", busy, launch_n - base); end
    in_valid = 1'b1; in_data = 4'h3;
    @(posedge slow_clk); #1;
    in_valid = 1'b0;
    @(posedge slow_clk); #1;
    exp_tx++;
    checks++; if (out !== 1'b1 || data_out !== 4'h3) begin failures++; $display("FAIL stray_launch: got out=%0b data=%0h exp 1 3", out, data_out); end
    n = 0;
    while (busy !== 1'b0 && n < 30) begin @(posedge slow_clk); #1; n++; end
    checks++; if (n > 10) begin failures++; $display("FAIL stray_ack_latency: got %0d cycles exp <=10", n); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL stray_timeout_err: got %0b exp 0", timeout_err); end
  endtask

  task automatic test_timeout();
    int base, n;
    base = launch_n;
    ack_en = 1'b0;
    @(posedge slow_clk); #1;
    in_valid = 1'b1; in_data = 4'h7;
    @(posedge slow_clk); #1;
    in_data = 4'h8;
    @(posedge slow_clk); #1;
    in_valid = 1'b0;
    exp_tx++;
    checks++; if (out !== 1'b1 || data_out !== 4'h7) begin failures++; $display("FAIL timeout_launch: got out=%0b data=%0h exp 1 7", out, data_out); end
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin @(posedge slow_clk); #1; n++; end
    ack_en = 1'b1; ack_delay = 3;
    checks++; if (n !== 16) begin failures++; $display("FAIL timeout_latency: got %0d edges exp 16", n); end
    n = 0;
    while (busy !== 1'b0 && n < 40) begin @(posedge slow_clk); #1; n++; end
    exp_tx++;
    checks++; if (launch_n - base !== 2 || launch_log[base + 1] !== 4'h8) begin failures++; $display("FAIL timeout_next_word: got n=%0d w=%0h exp n=2 w=8", launch_n - base, launch_log[base + 1]); end
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL timeout_sticky: got err=%0b busy=%0b exp 1 0", timeout_err, busy); end
    checks++; if (tx_count !== exp_txc()) begin failures++; $display("FAIL timeout_tx_count: got %0d exp %0d", tx_count, exp_txc()); end
  endtask

  task automatic test_reset_mid();
    int base;
    ack_en = 1'b0;
    @(posedge slow_clk); #1;
    in_valid = 1'b1; in_data = 4'h9;
    @(posedge slow_clk); #1;
    in_data = 4'hA;
    @(posedge slow_clk); #1;
    in_data = 4'hB;
    @(posedge slow_clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge slow_clk);
    #1;
    checks++; if (level !== 3'd2 || data_out !== 4'h9) begin failures++; $display("FAIL mid_pre_reset: got level=%0d data=%0h exp 2 9", level, data_out); end
    rst = 1'b1;
    #1;
    exp_tx = 0;
    checks++; if (out !== 1'b0 || level !== 3'd0 || data_out !== 4'h0) begin failures++; $display("FAIL mid_reset_state: got out=%0b level=%0d data=%0h exp 0 0 0", out, level, data_out); end
    checks++; if (tx_count !== exp_txc() || timeout_err !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_flags: got tx=%0d err=%0b rdy=%0b exp %0d 0 0", tx_count, timeout_err, in_ready, exp_txc()); end
    repeat (2) @(posedge slow_clk);
    #1;
    rst = 1'b0;
    ack_en = 1'b1;
    base = launch_n;
    repeat (20) @(posedge slow_clk);
    #1;
    checks++; if (launch_n !== base || busy !== 1'b0 || out !== 1'b0) begin failures++; $display("FAIL mid_no_relaunch: got launches=%0d busy=%0b exp 0 0", launch_n - base, busy); end
  endtask

  initial begin
    checks = 0; failures = 0; exp_tx = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0;
    ack_stray = 1'b0; ack_en = 1'b1; ack_delay = 3;
    test_reset();
    test_single();
    test_burst();
    test_stray_ack();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
